// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART transmit serializer.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int   C_DATA_WIDTH = 8;
    localparam int   C_DIV_WIDTH  = 16;
    localparam logic C_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Loadable divisor counter; o_tick marks the last cycle of a bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = C_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_restart,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_restart) begin
            r_div <= i_div;
            r_cnt <= '0;
        end else if (r_cnt == r_div) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
        end
    end

    assign o_tick = (r_cnt == r_div);

endmodule
`default_nettype wire

// File: rtl/uart_tx_ser.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ser
// Purpose  : UART TX serializer draining the TX FIFO read side.
//            Define UART_TX_PARITY_EN to build the optional parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int DIV_WIDTH  = C_DIV_WIDTH
) (
    input  logic                  clkr_i,
    input  logic                  rstn_i,
    input  logic                  tx_en_i,
    input  logic [DIV_WIDTH-1:0]  baud_div_i,
    input  logic                  stop2_i,
    input  logic                  parity_en_i,
    input  logic                  parity_odd_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  rden_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int                 c_bit_w    = $clog2(DATA_WIDTH + 1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_WIDTH - 1);

    uart_state_t           r_state;
    uart_state_t           w_next_state;
    logic [DIV_WIDTH-1:0]  r_div_lat;
    logic                  r_stop2_lat;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [c_bit_w-1:0]    w_bit_cnt_next;
    logic                  r_cap;
    logic                  r_tx;
    logic                  r_rden;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_tx_next;
    logic                  w_done_next;
    logic                  w_tick;
    logic                  w_start_ok;
    logic                  w_last_stop;

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk       (clkr_i),
        .rstn      (rstn_i),
        .i_restart (r_state == ST_FETCH),
        .i_div     (r_div_lat),
        .o_tick    (w_tick)
    );

    assign w_start_ok  = tx_en_i & ~empty_i;
    // bit counter is reused as the stop-bit counter, cleared on STOP entry
    assign w_last_stop = ~r_stop2_lat | r_bit_cnt[0];

`ifdef UART_TX_PARITY_EN
    logic r_par_en_lat;
    logic r_par_odd_lat;
    logic r_par;

    always_ff @(posedge clkr_i) begin
        if (!rstn_i) begin
            r_par_en_lat  <= 1'b0;
            r_par_odd_lat <= 1'b0;
            r_par         <= 1'b0;
        end else begin
            if (w_next_state == ST_FETCH) begin
                r_par_en_lat  <= parity_en_i;
                r_par_odd_lat <= parity_odd_i;
            end
            if (r_cap) begin
                r_par <= (^rd_data_i) ^ r_par_odd_lat;
            end
        end
    end
`else
    logic w_unused_parity;
    assign w_unused_parity = parity_en_i ^ parity_odd_i;
`endif

    always_comb begin
        w_next_state   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_done_next    = 1'b0;
        w_tx_next      = C_IDLE_LEVEL;

        // r_cap is set only during the first START cycle
        if (r_cap) begin
            w_shift_next = rd_data_i;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_next_state = ST_START;
            end
            ST_START: begin
                if (w_tick) begin
                    w_next_state   = ST_DATA;
                    w_bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == c_last_bit) begin
                        w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_next_state   = r_par_en_lat ? ST_PARITY : ST_STOP;
`else
                        w_next_state   = ST_STOP;
`endif
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + c_bit_w'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_next_state = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (w_last_stop) begin
                        w_done_next    = 1'b1;
                        w_bit_cnt_next = '0;
                        w_next_state   = w_start_ok ? ST_FETCH : ST_IDLE;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + c_bit_w'(1);
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // outputs are registered, so the line level follows the next state
        case (w_next_state)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = r_par;
`endif
            default:   w_tx_next = C_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clkr_i) begin
        if (!rstn_i) begin
            r_state     <= ST_IDLE;
            r_div_lat   <= '0;
            r_stop2_lat <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_cap       <= 1'b0;
            r_tx        <= C_IDLE_LEVEL;
            r_rden      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_cap     <= (r_state == ST_FETCH);
            r_tx      <= w_tx_next;
            r_rden    <= (w_next_state == ST_FETCH);
            r_busy    <= (w_next_state != ST_IDLE);
            r_done    <= w_done_next;
            if (w_next_state == ST_FETCH) begin
                r_div_lat   <= baud_div_i;
                r_stop2_lat <= stop2_i;
            end
        end
    end

    assign rden_o = r_rden;
    assign tx_o   = r_tx;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule
`default_nettype wire
